// File: rtl/hist_pkg.sv
// hist_pkg: shared types and constants for the frame histogram builder.
//   state_e     - controller states (IDLE, CLEAR, RECV, COUNT, DONE)
//   NUM_BINS    - number of histogram bins (one per 8-bit pixel value)
//   LANES       - pixel lanes per input word
//   LANE_W      - width of one lane in the input word
//   PIX_W       - significant pixel bits per lane (low byte of the lane)
//   LANE_IDX_W  - width of the lane index
//   WORD_W      - width of one input word
package hist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RECV  = 3'd2,
        COUNT = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int NUM_BINS   = 256;
    localparam int LANES      = 8;
    localparam int LANE_W     = 16;
    localparam int PIX_W      = 8;
    localparam int LANE_IDX_W = 3;
    localparam int WORD_W     = LANES * LANE_W;

endpackage

// File: rtl/histogram_builder_sat_inc.sv
// sat_inc: combinational saturating increment of one histogram bin.
//   val_i  - current bin count
//   val_o  - val_i + 1, held at the all-ones maximum instead of wrapping
module sat_inc #(
    parameter int BIN_W = 16
) (
    input  logic [BIN_W-1:0] val_i,
    output logic [BIN_W-1:0] val_o
);

    always_comb begin
        val_o = (&val_i) ? val_i : val_i + BIN_W'(1);
    end

endmodule

// File: rtl/histogram_builder.sv
// histogram_builder: builds the 256-bin histogram of one frame of 8-bit
// pixels delivered as 128-bit words of eight 16-bit lanes (low byte used).
// One pixel is counted per cycle; at end of frame the complete histogram is
// held stable and a one-cycle write enable is pulsed to the CDF accumulator.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - begin a frame (honoured in IDLE or DONE only)
//   in_valid     - in_data carries a word
//   in_ready     - a word is accepted this cycle when in_valid is also high
//   in_data      - eight lanes; pixel k = in_data[16k+7:16k]
//   hist         - bin array driven straight from the bin registers
//   ac_we        - one-cycle pulse on the first DONE cycle
//   hist_valid   - histogram complete and stable (DONE)
//   busy         - frame in progress (CLEAR, RECV or COUNT)
//   dbg_state_o  - current controller state, for observation
//
// Handshake: a word transfers on a cycle where in_valid and in_ready are both
// high at the rising edge. in_valid on a cycle with in_ready low is ignored and
// in_data need not be held; in_ready never depends on in_valid.
module histogram_builder
    import hist_pkg::*;
#(
    parameter int FRAME_WORDS = 9600,
    parameter int BIN_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [BIN_W-1:0]  hist [NUM_BINS-1:0],
    output logic              ac_we,
    output logic              hist_valid,
    output logic              busy,
    output state_e            dbg_state_o
);

    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     buf_q;
    logic [LANE_IDX_W-1:0] lane_q;
    logic [CNT_W-1:0]      word_cnt_q;
    logic                  last_q;     // the buffered word is the frame's last
    logic                  ac_we_q;
    logic [BIN_W-1:0]      bins_q [NUM_BINS-1:0];

    logic                  lane_end;
    logic                  accept;
    logic [PIX_W-1:0]      pix_sel;
    logic [BIN_W-1:0]      bin_inc;

    assign lane_end = (lane_q == LANE_IDX_W'(LANES - 1));
    assign accept   = in_valid & in_ready;
    // Low byte of the lane currently being counted.
    assign pix_sel  = buf_q[int'(lane_q) * LANE_W +: PIX_W];

    sat_inc #(.BIN_W(BIN_W)) u_sat_inc (
        .val_i (bins_q[pix_sel]),
        .val_o (bin_inc)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = CLEAR;
            CLEAR: state_d = RECV;
            RECV:  if (accept) state_d = COUNT;
            COUNT: begin
                // A handshake on the lane-7 cycle keeps us in COUNT with the
                // next word already buffered, giving one word per 8 cycles.
                if (lane_end) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else if (!accept) begin
                        state_d = RECV;
                    end
                end
            end
            DONE:  if (start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready    = (state_q == RECV) ||
                      ((state_q == COUNT) && lane_end && !last_q);
        hist_valid  = (state_q == DONE);
        busy        = (state_q == CLEAR) || (state_q == RECV) ||
                      (state_q == COUNT);
        ac_we       = ac_we_q;
        dbg_state_o = state_q;
    end

    // ---------------- word buffer, lane and word counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= '0;
            lane_q     <= '0;
            word_cnt_q <= '0;
            last_q     <= 1'b0;
            ac_we_q    <= 1'b0;
        end else begin
            // Registered so the pulse lands exactly on the first DONE cycle.
            ac_we_q <= (state_q == COUNT) && lane_end && last_q;

            if (state_q == CLEAR) begin
                lane_q     <= '0;
                word_cnt_q <= '0;
                last_q     <= 1'b0;
            end else if (accept) begin
                buf_q      <= in_data;
                lane_q     <= '0;
                last_q     <= (word_cnt_q == LAST_CNT);
                word_cnt_q <= (word_cnt_q == LAST_CNT) ? '0 : word_cnt_q + CNT_W'(1);
            end else if (state_q == COUNT) begin
                lane_q <= lane_q + LANE_IDX_W'(1);
            end
        end
    end

    // ---------------- bin array ----------------
    // Only one bin changes per cycle, so repeated pixel values never conflict.
    always_ff @(posedge clk) begin
        if (rst || (state_q == CLEAR)) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= '0;
            end
        end else if (state_q == COUNT) begin
            bins_q[pix_sel] <= bin_inc;
        end
    end

    assign hist = bins_q;

endmodule
